// File: rtl/spmv_seq_if.sv
// Vector and COO-nonzero streams feeding the SpMV job sequencer.
// master = stream source, slave = spmv_seq.
interface spmv_seq_if;
    logic              vec_valid;
    logic              vec_ready;
    logic signed [7:0] vec_data;
    logic              mat_valid;
    logic              mat_ready;
    logic [4:0]        mat_row;
    logic [4:0]        mat_col;
    logic signed [7:0] mat_data;
    logic              mat_last;

    modport master (
        output vec_valid, vec_data, mat_valid, mat_row, mat_col, mat_data, mat_last,
        input  vec_ready, mat_ready
    );

    modport slave (
        input  vec_valid, vec_data, mat_valid, mat_row, mat_col, mat_data, mat_last,
        output vec_ready, mat_ready
    );
endinterface

// File: rtl/spmv_seq.sv
// Job sequencer for the 32x32 SpMV engine: loads the vector, buffers all nonzeros, replays them
// as one gap-free weight burst, then tracks drain. Optional SPMV_SEQ_PERF_EN adds perf_cycles.
module spmv_seq #(
    parameter int NNZ_MAX       = 64,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    spmv_seq_if.slave         strm,
    output logic              eng_in_valid,
    output logic              eng_weight_valid,
    output logic [4:0]        eng_row,
    output logic [4:0]        eng_col,
    output logic signed [7:0] eng_data,
    input  logic              eng_out_valid,
    input  logic              eng_out_finish,
    output logic              busy,
    output logic              done,
    output logic [5:0]        rows_seen,
    output logic              err_ovf,
`ifdef SPMV_SEQ_PERF_EN
    output logic              err_timeout,
    output logic [15:0]       perf_cycles
`else
    output logic              err_timeout
`endif
);
    localparam int CW = $clog2(NNZ_MAX + 1);
    localparam int AW = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_VEC, S_MAT, S_BURST, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [4:0]        vec_idx;
    logic [CW-1:0]     count;
    logic [CW-1:0]     rd_ptr;
    logic [TW-1:0]     drain_tmr;
    logic [4:0]        mem_row  [NNZ_MAX];
    logic [4:0]        mem_col  [NNZ_MAX];
    logic signed [7:0] mem_data [NNZ_MAX];
    logic vec_fire, mat_fire, buf_full, wr_en, burst_last, drain_to;

    assign vec_fire   = strm.vec_valid && (state == S_VEC);
    assign mat_fire   = strm.mat_valid && (state == S_MAT);
    assign buf_full   = (count == CW'(NNZ_MAX));
    assign wr_en      = mat_fire && !buf_full && rst_n;
    assign burst_last = (rd_ptr == count - CW'(1));
    assign drain_to   = (drain_tmr == TW'(DRAIN_TIMEOUT - 1));
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        strm.vec_ready = 1'b0;
        strm.mat_ready = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = S_VEC;
            S_VEC: begin
                strm.vec_ready = 1'b1;
                if (vec_fire && vec_idx == 5'd31) state_nx = S_MAT;
            end
            S_MAT: begin
                strm.mat_ready = 1'b1;
                // An overflowed or empty job never reaches the engine's weight port.
                if (mat_fire && strm.mat_last) begin
                    if (err_ovf || buf_full || (count == '0 && !wr_en)) state_nx = S_DONE;
                    else                                                 state_nx = S_BURST;
                end
            end
            S_BURST: if (burst_last) state_nx = S_DRAIN;
            S_DRAIN: if (eng_out_finish || drain_to) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_row[count[AW-1:0]]  <= strm.mat_row;
            mem_col[count[AW-1:0]]  <= strm.mat_col;
            mem_data[count[AW-1:0]] <= strm.mat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_idx          <= '0;
            count            <= '0;
            rd_ptr           <= '0;
            drain_tmr        <= '0;
            eng_in_valid     <= 1'b0;
            eng_weight_valid <= 1'b0;
            eng_row          <= '0;
            eng_col          <= '0;
            eng_data         <= '0;
            rows_seen        <= '0;
            err_ovf          <= 1'b0;
            err_timeout      <= 1'b0;
        end else begin
            eng_in_valid     <= vec_fire;
            eng_weight_valid <= (state == S_BURST);
            if (vec_fire) begin
                eng_row  <= vec_idx;
                eng_col  <= '0;
                eng_data <= strm.vec_data;
                vec_idx  <= vec_idx + 5'd1;
            end else if (state == S_BURST) begin
                eng_row  <= mem_row[rd_ptr[AW-1:0]];
                eng_col  <= mem_col[rd_ptr[AW-1:0]];
                eng_data <= mem_data[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + CW'(1);
            end
            if (state == S_IDLE && start) begin
                rows_seen   <= '0;
                err_ovf     <= 1'b0;
                err_timeout <= 1'b0;
                vec_idx     <= '0;
                rd_ptr      <= '0;
            end
            if (mat_fire) begin
                if (buf_full) err_ovf <= 1'b1;
                else          count   <= count + CW'(1);
            end
            drain_tmr <= (state == S_DRAIN) ? drain_tmr + TW'(1) : '0;
            if (state == S_DRAIN) begin
                if (eng_out_valid && rows_seen != 6'd32) rows_seen <= rows_seen + 6'd1;
                if (!eng_out_finish && drain_to)         err_timeout <= 1'b1;
            end
            if (state == S_DONE) begin
                count  <= '0;
                rd_ptr <= '0;
            end
        end
    end

`ifdef SPMV_SEQ_PERF_EN
    // The start-acceptance cycle counts as cycle 1; the DONE cycle is the last one counted.
    always_ff @(posedge clk) begin
        if (!rst_n)                                    perf_cycles <= '0;
        else if (state == S_IDLE && start)             perf_cycles <= 16'd1;
        else if (busy && perf_cycles != 16'hFFFF)      perf_cycles <= perf_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_spmv_seq.sv
// Directed bench for spmv_seq: stimulus pushes expected engine strobes into queues,
// a negedge monitor pops and compares them as the DUT issues them.
module tb_spmv_seq;
    localparam int NNZ = 8;
    localparam int DT  = 64;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic eng_out_valid = 1'b0, eng_out_finish = 1'b0;
    logic eng_in_valid, eng_weight_valid, busy, done, err_ovf, err_timeout;
    logic [4:0] eng_row, eng_col;
    logic signed [7:0] eng_data;
    logic [5:0] rows_seen;
`ifdef SPMV_SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif

    spmv_seq_if bus();

    spmv_seq #(.NNZ_MAX(NNZ), .DRAIN_TIMEOUT(DT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .strm(bus),
        .eng_in_valid(eng_in_valid), .eng_weight_valid(eng_weight_valid),
        .eng_row(eng_row), .eng_col(eng_col), .eng_data(eng_data),
        .eng_out_valid(eng_out_valid), .eng_out_finish(eng_out_finish),
        .busy(busy), .done(done), .rows_seen(rows_seen), .err_ovf(err_ovf),
`ifdef SPMV_SEQ_PERF_EN
        .err_timeout(err_timeout), .perf_cycles(perf_cycles)
`else
        .err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, run = 0, last_run = 0, last_w_cyc = 0;
    bit mon_en = 1'b0, last_sent = 1'b0;
    logic [17:0] wq[$];
    logic [12:0] vq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (eng_in_valid && eng_weight_valid) chk("strobe_excl", 1, 0);
            if (eng_in_valid) begin
                if (vq.size() == 0) chk("vec_unexpected", 1, 0);
                else chk("vec_word", {eng_row, eng_data}, vq.pop_front());
            end
            if (eng_weight_valid) begin
                last_w_cyc = cyc;
                chk("w_after_last", last_sent, 1);
                if (wq.size() == 0) chk("w_unexpected", {eng_row, eng_col, eng_data}, 18'h3ffff);
                else chk("w_entry", {eng_row, eng_col, eng_data}, wq.pop_front());
                run++;
            end else if (run != 0) begin
                last_run = run;
                run = 0;
            end
        end
    end

    task automatic wait_ready(input bit is_vec, input string tag);
        int n = 0;
        forever begin
            @(negedge clk);
            if (is_vec ? bus.vec_ready : bus.mat_ready) break;
            if (++n > 50) begin chk(tag, 0, 1); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic start_job();
        last_sent = 1'b0;
        last_run  = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_vector(input int mode);
        for (int k = 0; k < 32; k++) begin
            logic [4:0] kk;
            logic signed [7:0] d;
            kk = 5'(k);
            d  = 8'((mode != 0) ? k * 5 - 70 : 1);
            vq.push_back({kk, d});
            bus.vec_valid = 1'b1;
            bus.vec_data  = d;
            wait_ready(1'b1, "vec_hs_timeout");
        end
        bus.vec_valid = 1'b0;
    endtask

    task automatic send_entry(input logic [4:0] r, input logic [4:0] c, input logic signed [7:0] d,
                              input bit last, input int gap, input bit store);
        if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
        bus.mat_valid = 1'b1;
        bus.mat_row   = r;
        bus.mat_col   = c;
        bus.mat_data  = d;
        bus.mat_last  = last;
        if (store) wq.push_back({r, c, d});
        wait_ready(1'b0, "mat_hs_timeout");
        bus.mat_valid = 1'b0;
        bus.mat_last  = 1'b0;
        if (last) last_sent = 1'b1;
    endtask

    task automatic engine_drain(input int n_rows, input bit fin);
        int n = 0;
        while (wq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("burst_drained", (wq.size() == 0), 1);
        @(posedge clk); #1;
        for (int i = 0; i < n_rows; i++) begin
            eng_out_valid = 1'b1;
            @(posedge clk); #1;
        end
        eng_out_valid = 1'b0;
        if (fin) begin
            eng_out_finish = 1'b1;
            @(posedge clk); #1 eng_out_finish = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound, output int dc);
        int n = 0;
        dc = -1;
        while (n < bound) begin
            @(negedge clk);
            if (done) begin dc = cyc; break; end
            n++;
        end
        chk("done_seen", (dc >= 0), 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic run_basic();
        int dc;
        start_job();
        send_vector(0);
        send_entry(5'd0, 5'd0, 8'sd2, 1'b0, 0, 1'b1);
        send_entry(5'd5, 5'd7, 8'sd3, 1'b0, 0, 1'b1);
        send_entry(5'd0, 5'd4, 8'sd4, 1'b1, 0, 1'b1);
        engine_drain(2, 1'b1);
        wait_done(20, dc);
        chk("s1_burst_len", last_run, 3);
        chk("s1_err_ovf", err_ovf, 0);
        chk("s1_err_timeout", err_timeout, 0);
        chk("s1_rows_seen", rows_seen, 2);
        chk("s1_vec_all_seen", vq.size(), 0);
    endtask

    initial begin
        int dc;
        bus.vec_valid = 1'b0; bus.vec_data = '0;
        bus.mat_valid = 1'b0; bus.mat_row = '0; bus.mat_col = '0;
        bus.mat_data  = '0;   bus.mat_last = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_valid", eng_in_valid, 0);
        chk("rst_w_valid", eng_weight_valid, 0);
        chk("rst_eng_bus", {eng_row, eng_col, eng_data}, 0);
        chk("rst_rows_seen", rows_seen, 0);
        chk("rst_errs", {err_ovf, err_timeout}, 0);
        chk("rst_readies", {bus.vec_ready, bus.mat_ready}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Scenario 1: basic three-entry job.
        run_basic();

        // Scenario 2: gapped arrivals, rows_seen saturates at 32.
        start_job();
        send_vector(1);
        send_entry(5'd31, 5'd31, -8'sd128, 1'b0, 5, 1'b1);
        send_entry(5'd1,  5'd2,  8'sd127,  1'b0, 5, 1'b1);
        send_entry(5'd16, 5'd0,  -8'sd1,   1'b0, 5, 1'b1);
        send_entry(5'd3,  5'd30, 8'sd5,    1'b1, 5, 1'b1);
        engine_drain(35, 1'b1);
        wait_done(20, dc);
        chk("s2_burst_len", last_run, 4);
        chk("s2_rows_sat", rows_seen, 32);
        chk("s2_err_ovf", err_ovf, 0);

        // Exactly NNZ_MAX entries: full buffer, no overflow.
        start_job();
        send_vector(0);
        for (int i = 0; i < NNZ; i++)
            send_entry(5'(i), 5'(31 - i), 8'(i * 7 - 20), (i == NNZ - 1), 0, 1'b1);
        engine_drain(0, 1'b1);
        wait_done(20, dc);
        chk("full_burst_len", last_run, NNZ);
        chk("full_err_ovf", err_ovf, 0);

        // Scenario 3: overflow, no weights at all.
        start_job();
        send_vector(1);
        for (int i = 0; i < NNZ + 2; i++)
            send_entry(5'(i), 5'(i), 8'(i), (i == NNZ + 1), 0, 1'b0);
        wait_done(5, dc);
        chk("ovf_err_ovf", err_ovf, 1);
        chk("ovf_no_weights", last_run, 0);
        chk("ovf_rows_seen", rows_seen, 0);

        // Scenario 4: single entry carrying mat_last.
        start_job();
        chk("start_clears_ovf", err_ovf, 0);
        send_vector(0);
        send_entry(5'd9, 5'd9, -8'sd5, 1'b1, 0, 1'b1);
        engine_drain(1, 1'b1);
        wait_done(20, dc);
        chk("one_burst_len", last_run, 1);
        chk("one_rows_seen", rows_seen, 1);

        // Scenario 5: engine never finishes.
        start_job();
        send_vector(0);
        send_entry(5'd2, 5'd3, 8'sd9, 1'b0, 0, 1'b1);
        send_entry(5'd4, 5'd5, 8'sd6, 1'b1, 0, 1'b1);
        engine_drain(0, 1'b0);
        wait_done(DT + 10, dc);
        chk("to_done_latency", dc - last_w_cyc, DT);
        chk("to_err_timeout", err_timeout, 1);
        chk("to_err_ovf", err_ovf, 0);

        // Scenario 6: reset during BURST, then a clean job.
        start_job();
        chk("start_clears_timeout", err_timeout, 0);
        send_vector(0);
        send_entry(5'd1, 5'd1, 8'sd1, 1'b0, 0, 1'b1);
        send_entry(5'd2, 5'd2, 8'sd2, 1'b0, 0, 1'b1);
        send_entry(5'd3, 5'd3, 8'sd3, 1'b1, 0, 1'b1);
        begin
            int n = 0;
            while (!eng_weight_valid && n < 20) begin @(negedge clk); n++; end
            chk("burst_started", eng_weight_valid, 1);
        end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_w_valid", eng_weight_valid, 0);
        wq.delete();
        vq.delete();
        run = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1'b1;
        run_basic();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
